// File: rtl/bf16_pkg_44.sv
// Shared types and constants for the BF16 dot-product dispatcher.
package bf16_pkg_44;

  localparam int BF16_W  = 16;
  localparam int VEC_LEN = 12;
  localparam int VEC_W   = BF16_W * VEC_LEN;

  // Index of the last element slot in a bank.
  localparam logic [3:0] LAST_IDX = 4'(VEC_LEN - 1);

  localparam logic [BF16_W-1:0] ZERO = 16'h0000;
  localparam logic [BF16_W-1:0] ONE  = 16'h3F80;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_BUSY    = 2'd1,
    D_RELEASE = 2'd2,
    D_ERR     = 2'd3
  } disp_state_t;

endpackage

// File: rtl/bf16_vec_bank_44.sv
// One operand bank: 12 entries of {b, a} BF16 pairs with indexed write and a
// flat 192-bit read of each operand vector (element k at bits [16k+15:16k]).
module bf16_vec_bank_44
  import bf16_pkg_44::*;
(
  input  logic              clk_44,
  input  logic              rst_n_44,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [BF16_W-1:0] wr_a,
  input  logic [BF16_W-1:0] wr_b,
  output logic [VEC_W-1:0]  a_flat,
  output logic [VEC_W-1:0]  b_flat
);

  logic [2*BF16_W-1:0] mem [VEC_LEN];

  // Store one element pair; indices beyond the last slot are ignored.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      for (int k = 0; k < VEC_LEN; k++) mem[k] <= '0;
    end else if (wr_en && (wr_idx <= LAST_IDX)) begin
      mem[wr_idx] <= {wr_b, wr_a};
    end
  end

  // Flatten the register file into the engine's vector layout.
  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int k = 0; k < VEC_LEN; k++) begin
      a_flat[k*BF16_W +: BF16_W] = mem[k][BF16_W-1:0];
      b_flat[k*BF16_W +: BF16_W] = mem[k][2*BF16_W-1:BF16_W];
    end
  end

endmodule

// File: rtl/bf16_dot_dispatcher_44.sv
// Job front-end for the BF16 dot-product engine: packs operand pairs into two
// ping-pong banks, launches the engine over a level start/done handshake,
// holds each result in a one-entry output slot and watches for a hung engine.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// D_IDLE    | waiting for a full compute bank and a free result slot
// D_BUSY    | mac_start high, watchdog running, waiting for done
// D_RELEASE | result captured, waiting for the engine to drop done
// D_ERR     | watchdog expired; stalled until reset
module bf16_dot_dispatcher_44
  import bf16_pkg_44::*;
#(
  parameter int TIMEOUT_44 = 255
) (
  input  logic              clk_44,
  input  logic              rst_n_44,
  input  logic              in_valid_44,
  output logic              in_ready_44,
  input  logic [15:0]       in_a_44,
  input  logic [15:0]       in_b_44,
  output logic              mac_start_44,
  output logic [191:0]      mac_a_flat_44,
  output logic [191:0]      mac_b_flat_44,
  input  logic              mac_done_44,
  input  logic [15:0]       mac_result_44,
  output logic              out_valid_44,
  input  logic              out_ready_44,
  output logic [15:0]       out_data_44,
  output logic [7:0]        job_count_44,
  output logic              timeout_err_44
);

  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT_44);

  disp_state_t       state_q, state_d;
  logic [1:0]        full_q, full_set, full_clr;
  logic              fill_bank_q;
  logic [3:0]        fill_idx_q;
  logic              comp_bank_q;
  logic [7:0]        wd_cnt_q;
  logic              out_valid_q;
  logic [BF16_W-1:0] out_data_q;
  logic [7:0]        job_count_q;
  logic              timeout_err_q;

  logic              accept, fill_done, slot_free, comp_ready;
  logic              launch, job_done, wd_expire;
  logic [VEC_W-1:0]  a_flat0, b_flat0, a_flat1, b_flat1;

  assign in_ready_44 = !full_q[fill_bank_q] && !timeout_err_q;
  assign accept      = in_valid_44 && in_ready_44;
  assign fill_done   = accept && (fill_idx_q == LAST_IDX);
  assign slot_free   = !out_valid_q || out_ready_44;
  // A bank completing this very cycle counts as full so the launch is not
  // delayed by the extra cycle it takes the full flag to register.
  assign comp_ready  = full_q[comp_bank_q] ||
                       (fill_done && (fill_bank_q == comp_bank_q));

  assign full_set[0] = fill_done && !fill_bank_q;
  assign full_set[1] = fill_done &&  fill_bank_q;
  assign full_clr[0] = job_done  && !comp_bank_q;
  assign full_clr[1] = job_done  &&  comp_bank_q;

  bf16_vec_bank_44 u_bank0 (
    .clk_44  (clk_44),
    .rst_n_44(rst_n_44),
    .wr_en   (accept && !fill_bank_q),
    .wr_idx  (fill_idx_q),
    .wr_a    (in_a_44),
    .wr_b    (in_b_44),
    .a_flat  (a_flat0),
    .b_flat  (b_flat0)
  );

  bf16_vec_bank_44 u_bank1 (
    .clk_44  (clk_44),
    .rst_n_44(rst_n_44),
    .wr_en   (accept && fill_bank_q),
    .wr_idx  (fill_idx_q),
    .wr_a    (in_a_44),
    .wr_b    (in_b_44),
    .a_flat  (a_flat1),
    .b_flat  (b_flat1)
  );

  assign mac_a_flat_44  = comp_bank_q ? a_flat1 : a_flat0;
  assign mac_b_flat_44  = comp_bank_q ? b_flat1 : b_flat0;
  assign mac_start_44   = (state_q == D_BUSY);
  assign out_valid_44   = out_valid_q;
  assign out_data_44    = out_data_q;
  assign job_count_44   = job_count_q;
  assign timeout_err_44 = timeout_err_q;

  // Dispatch next-state and one-cycle event strobes.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    job_done  = 1'b0;
    wd_expire = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (comp_ready && slot_free) begin
          launch  = 1'b1;
          state_d = D_BUSY;
        end
      end
      D_BUSY: begin
        if (mac_done_44) begin
          job_done = 1'b1;
          state_d  = D_RELEASE;
        end else if (wd_cnt_q <= 8'd1) begin
          wd_expire = 1'b1;
          state_d   = D_ERR;
        end
      end
      D_RELEASE: begin
        if (!mac_done_44) state_d = D_IDLE;
      end
      D_ERR:   state_d = D_ERR;
      default: state_d = D_IDLE;
    endcase
  end

  // Dispatch state register.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) state_q <= D_IDLE;
    else           state_q <= state_d;
  end

  // Fill pointer: walk the element index and swap banks after the last slot.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      fill_idx_q  <= 4'd0;
      fill_bank_q <= 1'b0;
    end else if (accept) begin
      fill_idx_q <= fill_done ? 4'd0 : fill_idx_q + 4'd1;
      if (fill_done) fill_bank_q <= !fill_bank_q;
    end
  end

  // Bank full flags and compute-bank pointer; fill and release always hit
  // different banks so both may land in one cycle.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      full_q      <= 2'b00;
      comp_bank_q <= 1'b0;
    end else begin
      full_q <= (full_q & ~full_clr) | full_set;
      if (job_done) comp_bank_q <= !comp_bank_q;
    end
  end

  // Watchdog: down-counter loaded at launch, expiry taken at terminal count 1.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      wd_cnt_q <= 8'd0;
    end else if (launch) begin
      wd_cnt_q <= WD_LOAD;
    end else if ((state_q == D_BUSY) && !mac_done_44 && (wd_cnt_q != 8'd0)) begin
      wd_cnt_q <= wd_cnt_q - 8'd1;
    end
  end

  // One-entry result slot; a launch only happens when it is free, so a
  // capture never collides with an occupied slot.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      out_valid_q <= 1'b0;
      out_data_q  <= ZERO;
    end else if (job_done) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mac_result_44;
    end else if (out_valid_q && out_ready_44) begin
      out_valid_q <= 1'b0;
    end
  end

  // Completed-job counter and sticky watchdog error.
  always_ff @(posedge clk_44 or negedge rst_n_44) begin
    if (!rst_n_44) begin
      job_count_q   <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      if (job_done)  job_count_q   <= job_count_q + 8'd1;
      if (wd_expire) timeout_err_q <= 1'b1;
    end
  end

endmodule
